// File: rtl/bheap_pq_if.sv
// bheap_pq_if: command/response bundle between a host and the bheap_pq core.
// Latency: none, plain wires.
// Backpressure: CmdReady from the core holds the host's command in place.
interface bheap_pq_if #(
  parameter int WIDTH = 8
);
  logic             CmdValid;
  logic             CmdReady;
  logic [1:0]       CmdOp;
  logic [WIDTH-1:0] CmdKey;
  logic             RspValid;
  logic             RspErr;
  logic [WIDTH-1:0] RspData;

  modport master (
    output CmdValid, CmdOp, CmdKey,
    input  CmdReady, RspValid, RspErr, RspData
  );

  modport slave (
    input  CmdValid, CmdOp, CmdKey,
    output CmdReady, RspValid, RspErr, RspData
  );
endinterface

// File: rtl/bheap_pq.sv
// bheap_pq: sequential max-heap priority queue, one compare/swap step per clock.
// Latency: response pulse the cycle after accept; insert busy <= LEVELS, extract/replace busy <= LEVELS-1.
// Backpressure: CmdReady only in IDLE; errors and no-ops never leave IDLE.
// Optional host readback port (RD/Addr/DataOut) is built when BHEAP_PQ_READBACK_EN is defined.
module bheap_pq #(
  parameter int WIDTH     = 8,
  parameter int LEVELS    = 4,
  parameter int ADDRWIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  bheap_pq_if.slave        bus,
  output logic [LEVELS:0]  Count,
  output logic             Empty,
  output logic             Full,
  output logic [WIDTH-1:0] Max
`ifdef BHEAP_PQ_READBACK_EN
  ,
  input  logic                 RD,
  input  logic [ADDRWIDTH-1:0] Addr,
  output logic [WIDTH-1:0]     DataOut
`endif
);
  localparam int CAP   = 2**LEVELS - 1;
  localparam int SLOTS = 2**LEVELS;

  localparam logic [1:0] OP_INS = 2'b00;
  localparam logic [1:0] OP_EXT = 2'b01;
  localparam logic [1:0] OP_REP = 2'b10;

  typedef enum logic [1:0] {IDLE, SIFT_UP, SIFT_DOWN} state_t;

  // The readback address must be able to name every heap slot.
  if (ADDRWIDTH < LEVELS) begin : g_addr_too_narrow
    $error("bheap_pq: ADDRWIDTH narrower than LEVELS");
  end

  state_t           state, state_nxt;
  logic [WIDTH-1:0] heap [SLOTS];   // slot 0 unused, root at 1
  logic [LEVELS:0]  cnt;
  logic [LEVELS-1:0] idx;
  logic             rsp_vld, rsp_err;
  logic [WIDTH-1:0] rsp_dat;

  logic             accept, is_empty, is_full;
  logic [LEVELS-1:0] par_idx, ins_idx, last_idx, win_idx;
  logic [LEVELS:0]  l_idx, r_idx;
  logic             l_pres, r_pres, l_win, r_win, up_done, go_deeper;
  logic [WIDTH-1:0] cur_key, par_key, l_key, r_key, win_key;

  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == (LEVELS+1)'(CAP));
  assign accept   = bus.CmdValid && (state == IDLE);
  assign ins_idx  = cnt[LEVELS-1:0] + LEVELS'(1);
  assign last_idx = cnt[LEVELS-1:0];

  // Neighbourhood of the current sift index; children beyond Count never win.
  assign par_idx   = idx >> 1;
  assign l_idx     = {idx, 1'b0};
  assign r_idx     = {idx, 1'b1};
  assign l_pres    = (l_idx <= cnt);
  assign r_pres    = (r_idx <= cnt);
  assign cur_key   = heap[idx];
  assign par_key   = heap[par_idx];
  assign l_key     = heap[l_idx[LEVELS-1:0]];
  assign r_key     = heap[r_idx[LEVELS-1:0]];
  assign l_win     = l_pres && (l_key > cur_key) && (!r_pres || (l_key >= r_key));
  assign r_win     = r_pres && (r_key > cur_key) && (!l_pres || (r_key > l_key));
  assign win_idx   = r_win ? r_idx[LEVELS-1:0] : l_idx[LEVELS-1:0];
  assign win_key   = r_win ? r_key : l_key;
  // Stop right after a swap that lands on a node with no live children.
  assign go_deeper = ({win_idx, 1'b0} <= cnt);
  assign up_done   = (idx == LEVELS'(1)) || (par_key >= cur_key);

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode and ready.
  always_comb begin
    state_nxt    = state;
    bus.CmdReady = 1'b0;
    case (state)
      IDLE: begin
        bus.CmdReady = 1'b1;
        if (accept) begin
          case (bus.CmdOp)
            OP_INS:  if (!is_full) state_nxt = SIFT_UP;
            OP_EXT:  if (!is_empty && cnt != (LEVELS+1)'(1)) state_nxt = SIFT_DOWN;
            OP_REP:  if (!is_empty) state_nxt = SIFT_DOWN;
            default: state_nxt = IDLE;
          endcase
        end
      end
      SIFT_UP:   if (up_done) state_nxt = IDLE;
      SIFT_DOWN: if (!(l_win || r_win) || !go_deeper) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Heap storage, count, sift index and response register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int k = 0; k < SLOTS; k++) heap[k] <= '0;
      cnt     <= '0;
      idx     <= LEVELS'(1);
      rsp_vld <= 1'b0;
      rsp_err <= 1'b0;
      rsp_dat <= '0;
    end else begin
      rsp_vld <= 1'b0;
      rsp_err <= 1'b0;
      rsp_dat <= '0;
      case (state)
        IDLE: if (accept) begin
          rsp_vld <= 1'b1;
          case (bus.CmdOp)
            OP_INS: if (is_full) rsp_err <= 1'b1;
              else begin
                heap[ins_idx] <= bus.CmdKey;
                cnt           <= cnt + 1'b1;
                idx           <= ins_idx;
              end
            OP_EXT: if (is_empty) rsp_err <= 1'b1;
              else begin
                rsp_dat        <= heap[1];
                heap[1]        <= heap[last_idx];
                heap[last_idx] <= '0;   // wins over the root write when one key is left
                cnt            <= cnt - 1'b1;
                idx            <= LEVELS'(1);
              end
            OP_REP: if (is_empty) rsp_err <= 1'b1;
              else begin
                rsp_dat <= heap[1];
                heap[1] <= bus.CmdKey;
                idx     <= LEVELS'(1);
              end
            default: ;
          endcase
        end
        SIFT_UP: if (!up_done) begin
          heap[idx]     <= par_key;
          heap[par_idx] <= cur_key;
          idx           <= par_idx;
        end
        SIFT_DOWN: if (l_win || r_win) begin
          heap[idx]     <= win_key;
          heap[win_idx] <= cur_key;
          idx           <= win_idx;
        end
        default: ;
      endcase
    end
  end

  assign bus.RspValid = rsp_vld;
  assign bus.RspErr   = rsp_err;
  assign bus.RspData  = rsp_dat;
  assign Count        = cnt;
  assign Empty        = is_empty;
  assign Full         = is_full;
  assign Max          = is_empty ? '0 : heap[1];

`ifdef BHEAP_PQ_READBACK_EN
  // Host inspection port, purely combinational.
  assign DataOut = (RD && Addr >= ADDRWIDTH'(1) && Addr <= ADDRWIDTH'(CAP))
                   ? heap[Addr[LEVELS-1:0]] : {WIDTH{1'bz}};
`endif
endmodule

// File: tb/tb_bheap_pq.sv
// tb_bheap_pq: directed bench for the bheap_pq max-heap queue.
module tb_bheap_pq;
  logic       Clk;
  logic       Reset_n;
  logic [4:0] Count;
  logic       Empty, Full;
  logic [7:0] Max;
  int         n_pass = 0;
  int         n_total = 0;

  bheap_pq_if #(.WIDTH(8)) bus ();

`ifdef BHEAP_PQ_READBACK_EN
  logic       RD = 1'b0;
  logic [7:0] Addr = 8'd0;
  wire  [7:0] DataOut;
`endif

  bheap_pq #(.WIDTH(8), .LEVELS(4), .ADDRWIDTH(8)) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .bus(bus),
    .Count(Count),
    .Empty(Empty),
    .Full(Full),
    .Max(Max)
`ifdef BHEAP_PQ_READBACK_EN
    ,
    .RD(RD),
    .Addr(Addr),
    .DataOut(DataOut)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Issues one command from a negedge, returns the response and busy-cycle count.
  task automatic do_cmd(input logic [1:0] op, input logic [7:0] key,
                        output logic vld, output logic err, output logic [7:0] dat,
                        output int busy);
    int n = 0;
    while (bus.CmdReady !== 1'b1 && n < 50) begin @(negedge Clk); n++; end
    n_total++;
    if (n >= 50) $display("FAIL ready_wait: CmdReady=%b required 1", bus.CmdReady);
    else n_pass++;
    bus.CmdOp = op; bus.CmdKey = key; bus.CmdValid = 1'b1;
    @(negedge Clk);
    vld = bus.RspValid; err = bus.RspErr; dat = bus.RspData;
    bus.CmdValid = 1'b0;
    busy = 0;
    while (bus.CmdReady !== 1'b1 && busy < 50) begin @(negedge Clk); busy++; end
    n_total++;
    if (busy >= 50) $display("FAIL busy_timeout: busy=%0d required <50", busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    bus.CmdValid = 1'b0; bus.CmdOp = 2'b00; bus.CmdKey = 8'd0;
    repeat (2) @(negedge Clk);
    n_total++; if ({bus.CmdReady, bus.RspValid, bus.RspErr} !== 3'b100)
      $display("FAIL rst_ctrl: rdy/vld/err=%b required 100", {bus.CmdReady, bus.RspValid, bus.RspErr}); else n_pass++;
    n_total++; if (bus.RspData !== 8'd0) $display("FAIL rst_data: %0d required 0", bus.RspData); else n_pass++;
    n_total++; if ({Count, Empty, Full} !== {5'd0, 1'b1, 1'b0})
      $display("FAIL rst_status: count=%0d empty=%b full=%b required 0/1/0", Count, Empty, Full); else n_pass++;
    n_total++; if (Max !== 8'd0) $display("FAIL rst_max: %0d required 0", Max); else n_pass++;
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_insert();
    logic [7:0] keys [4] = '{8'd5, 8'd3, 8'd9, 8'd7};
    logic v, e; logic [7:0] d; int b;
    for (int i = 0; i < 4; i++) begin
      do_cmd(2'b00, keys[i], v, e, d, b);
      n_total++; if ({v, e, d} !== {1'b1, 1'b0, 8'd0})
        $display("FAIL ins_rsp[%0d]: vld=%b err=%b data=%0d required 1/0/0", i, v, e, d); else n_pass++;
    end
    n_total++; if (Count !== 5'd4) $display("FAIL ins_count: %0d required 4", Count); else n_pass++;
    n_total++; if (Max !== 8'd9) $display("FAIL ins_max: %0d required 9", Max); else n_pass++;
  endtask

  task automatic test_extract();
    logic [7:0] exp [4] = '{8'd9, 8'd7, 8'd5, 8'd3};
    logic v, e; logic [7:0] d; int b;
    for (int i = 0; i < 4; i++) begin
      do_cmd(2'b01, 8'd0, v, e, d, b);
      n_total++; if ({v, e, d} !== {1'b1, 1'b0, exp[i]})
        $display("FAIL ext_rsp[%0d]: vld=%b err=%b data=%0d required 1/0/%0d", i, v, e, d, exp[i]); else n_pass++;
    end
    do_cmd(2'b01, 8'd0, v, e, d, b);
    n_total++; if ({v, e, d} !== {1'b1, 1'b1, 8'd0})
      $display("FAIL ext_empty_err: vld=%b err=%b data=%0d required 1/1/0", v, e, d); else n_pass++;
    n_total++; if ({Count, Empty} !== {5'd0, 1'b1})
      $display("FAIL ext_empty_status: count=%0d empty=%b required 0/1", Count, Empty); else n_pass++;
    n_total++; if (b !== 0) $display("FAIL ext_err_busy: %0d required 0", b); else n_pass++;
  endtask

  task automatic test_full();
    logic v, e; logic [7:0] d; int b;
    for (int k = 1; k <= 15; k++) begin
      do_cmd(2'b00, 8'(k), v, e, d, b);
      n_total++; if (e !== 1'b0) $display("FAIL fill_err[%0d]: %b required 0", k, e); else n_pass++;
      if (k == 8 || k == 15) begin
        n_total++; if (b !== 4) $display("FAIL root_path_busy[%0d]: %0d required 4", k, b); else n_pass++;
      end
    end
    n_total++; if ({Full, Count, Max} !== {1'b1, 5'd15, 8'd15})
      $display("FAIL full_status: full=%b count=%0d max=%0d required 1/15/15", Full, Count, Max); else n_pass++;
    do_cmd(2'b00, 8'd20, v, e, d, b);
    n_total++; if ({v, e, d} !== {1'b1, 1'b1, 8'd0})
      $display("FAIL full_ins_err: vld=%b err=%b data=%0d required 1/1/0", v, e, d); else n_pass++;
    n_total++; if ({Count, Max, b[3:0]} !== {5'd15, 8'd15, 4'd0})
      $display("FAIL full_unchanged: count=%0d max=%0d busy=%0d required 15/15/0", Count, Max, b); else n_pass++;
    for (int k = 15; k >= 1; k--) begin
      do_cmd(2'b01, 8'd0, v, e, d, b);
      n_total++; if ({e, d} !== {1'b0, 8'(k)})
        $display("FAIL drain[%0d]: err=%b data=%0d required 0/%0d", k, e, d, k); else n_pass++;
      n_total++; if (b > 3) $display("FAIL drain_busy[%0d]: %0d required <=3", k, b); else n_pass++;
    end
    n_total++; if (Empty !== 1'b1) $display("FAIL drain_empty: %b required 1", Empty); else n_pass++;
  endtask

  task automatic test_replace();
    logic [7:0] keys [3] = '{8'd9, 8'd7, 8'd5};
    logic [7:0] exp [3] = '{8'd7, 8'd5, 8'd1};
    logic v, e; logic [7:0] d; int b;
    for (int i = 0; i < 3; i++) do_cmd(2'b00, keys[i], v, e, d, b);
    do_cmd(2'b10, 8'd1, v, e, d, b);
    n_total++; if ({v, e, d} !== {1'b1, 1'b0, 8'd9})
      $display("FAIL rep_rsp: vld=%b err=%b data=%0d required 1/0/9", v, e, d); else n_pass++;
    n_total++; if ({Max, Count} !== {8'd7, 5'd3})
      $display("FAIL rep_status: max=%0d count=%0d required 7/3", Max, Count); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      do_cmd(2'b01, 8'd0, v, e, d, b);
      n_total++; if ({e, d} !== {1'b0, exp[i]})
        $display("FAIL rep_ext[%0d]: err=%b data=%0d required 0/%0d", i, e, d, exp[i]); else n_pass++;
    end
    do_cmd(2'b10, 8'd3, v, e, d, b);
    n_total++; if ({v, e, d, Count} !== {1'b1, 1'b1, 8'd0, 5'd0})
      $display("FAIL rep_empty_err: vld=%b err=%b data=%0d count=%0d required 1/1/0/0", v, e, d, Count); else n_pass++;
  endtask

  task automatic test_ties();
    logic v, e; logic [7:0] d; int b;
    for (int i = 0; i < 3; i++) do_cmd(2'b00, 8'd4, v, e, d, b);
    for (int i = 0; i < 3; i++) begin
      do_cmd(2'b01, 8'd0, v, e, d, b);
      n_total++; if ({v, e, d} !== {1'b1, 1'b0, 8'd4})
        $display("FAIL tie_ext[%0d]: vld=%b err=%b data=%0d required 1/0/4", i, v, e, d); else n_pass++;
    end
    n_total++; if (Empty !== 1'b1) $display("FAIL tie_empty: %b required 1", Empty); else n_pass++;
  endtask

  task automatic test_reserved();
    logic v, e; logic [7:0] d; int b;
    do_cmd(2'b00, 8'd6, v, e, d, b);
    do_cmd(2'b11, 8'd33, v, e, d, b);
    n_total++; if ({v, e, d} !== {1'b1, 1'b0, 8'd0})
      $display("FAIL nop_rsp: vld=%b err=%b data=%0d required 1/0/0", v, e, d); else n_pass++;
    n_total++; if ({Count, Max, b[3:0]} !== {5'd1, 8'd6, 4'd0})
      $display("FAIL nop_state: count=%0d max=%0d busy=%0d required 1/6/0", Count, Max, b); else n_pass++;
    do_cmd(2'b01, 8'd0, v, e, d, b);
  endtask

`ifdef BHEAP_PQ_READBACK_EN
  task automatic test_readback();
    logic [7:0] keys [3] = '{8'd9, 8'd7, 8'd5};
    logic v, e; logic [7:0] d; int b;
    for (int i = 0; i < 3; i++) do_cmd(2'b00, keys[i], v, e, d, b);
    RD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      Addr = 8'(i + 1); #1;
      n_total++; if (DataOut !== keys[i])
        $display("FAIL rd_addr[%0d]: %0d required %0d", i + 1, DataOut, keys[i]); else n_pass++;
    end
    Addr = 8'd0; #1;
    n_total++; if (DataOut !== 8'bzzzz_zzzz) $display("FAIL rd_addr0: %b required z", DataOut); else n_pass++;
    Addr = 8'd16; #1;
    n_total++; if (DataOut !== 8'bzzzz_zzzz) $display("FAIL rd_addr16: %b required z", DataOut); else n_pass++;
    RD = 1'b0;
    @(negedge Clk);
  endtask
`endif

  task automatic test_reset_mid();
    logic v, e; logic [7:0] d; int b;
    int saw;
    do_cmd(2'b00, 8'd1, v, e, d, b);
    do_cmd(2'b00, 8'd2, v, e, d, b);
    bus.CmdOp = 2'b00; bus.CmdKey = 8'd8; bus.CmdValid = 1'b1;
    @(negedge Clk);
    bus.CmdValid = 1'b0;
    n_total++; if (bus.CmdReady !== 1'b0) $display("FAIL mid_busy: CmdReady=%b required 0", bus.CmdReady); else n_pass++;
    Reset_n = 1'b0; #1;
    n_total++; if ({Count, Empty, Max} !== {5'd0, 1'b1, 8'd0})
      $display("FAIL mid_rst_status: count=%0d empty=%b max=%0d required 0/1/0", Count, Empty, Max); else n_pass++;
    n_total++; if ({bus.CmdReady, bus.RspValid} !== 2'b10)
      $display("FAIL mid_rst_ctrl: rdy/vld=%b required 10", {bus.CmdReady, bus.RspValid}); else n_pass++;
    @(negedge Clk);
    Reset_n = 1'b1;
    saw = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      if (bus.RspValid === 1'b1) saw++;
    end
    n_total++; if ({saw[3:0], Count} !== {4'd0, 5'd0})
      $display("FAIL mid_no_rsp: pulses=%0d count=%0d required 0/0", saw, Count); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_insert();
    test_extract();
    test_full();
    test_replace();
    test_ties();
    test_reserved();
`ifdef BHEAP_PQ_READBACK_EN
    test_readback();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
